instr_mem_responder: RTL

Multi-cycle instruction-memory responder: the memory side of the processor's instruction-fetch interface. It accepts one fetch request at a time from the PC/fetch logic and returns the addressed 32-bit instruction word after a fixed, parameterised latency through a valid/ready handshake. A separate load port lets a bench or boot loader write program words into the array. It replaces the zero-latency combinational fetch path once the core moves to a stalled, multi-cycle fetch.

---
 rtl/instr_mem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for a multi-cycle fetch path.
// Accepts one fetch at a time, returns the addressed word LATENCY cycles
// later through a valid/ready handshake, and has an independent load port
// used to fill the array with program words.
module instr_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter only has to hold LATENCY-1; keep at least one bit.
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] counter;
  logic [CW-1:0] counter_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          req_bad;
  logic [AW-1:0] req_idx;
  logic          ld_ok;
  logic [AW-1:0] ld_idx;

  // Address decode: word index from bits above the byte offset; anything
  // misaligned or beyond the array is flagged (requests) or dropped (loads).
  always_comb begin
    accept  = req_valid && req_ready;
    req_idx = req_addr[AW+1:2];
    req_bad = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
    ld_idx  = ld_addr[AW+1:2];
    ld_ok   = (ld_addr[1:0] == 2'b00) && !(|ld_addr[31:AW+2]);
  end

  // Next-state logic for the one-outstanding-request fetch FSM.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = S_RESP;
          end else begin
            state_next   = S_WAIT;
            counter_next = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (counter == CW'(1)) begin
          state_next   = S_RESP;
          counter_next = '0;
        end else begin
          counter_next = counter - CW'(1);
        end
      end
      S_RESP: begin
        // Counter is frozen here regardless of how long back-pressure lasts.
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next   = S_IDLE;
        counter_next = '0;
      end
    endcase
  end

  // State, counter and the handshake outputs are all flops, so req_ready and
  // rsp_valid have no combinational path from req_valid or rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      counter   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      req_ready <= (state_next == S_IDLE);
      rsp_valid <= (state_next == S_RESP);
      busy      <= (state_next != S_IDLE);
    end
  end

  // Response capture at the accept edge; the word read here is the
  // pre-write value if a load hits the same word on the same edge, and it
  // stays put until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_instr <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= req_bad;
      rsp_instr <= req_bad ? 32'h0000_0000 : mem[req_idx];
    end
  end

  // Load port: writes land in the array in any FSM state; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

endmodule
